// File: rtl/dsp_op_sequencer_if.sv
// Request/result handshake bundle between a client and the DSP op sequencer.
interface dsp_op_sequencer_if #(
  parameter int WIDTH      = 33,
  parameter int SHIFT_BITS = 2
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic                  req_mac;
  logic [WIDTH-1:0]      req_aa;
  logic [WIDTH-1:0]      req_bb;
  logic [2*WIDTH-1:0]    req_cc;
  logic [SHIFT_BITS-1:0] req_shamt;
  logic                  req_dir;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*WIDTH-1:0]    res_data;

  modport master (
    output req_valid, req_op, req_mac, req_aa, req_bb, req_cc, req_shamt, req_dir, res_ready,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_op, req_mac, req_aa, req_bb, req_cc, req_shamt, req_dir, res_ready,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_op_sequencer.sv
// Sequences multiply / multiply-accumulate / shift ops onto the fused DSP slice
// and buffers completed results in a 2-deep first-word-fall-through FIFO.
module dsp_op_sequencer #(
  parameter int WIDTH      = 33,
  parameter int SHIFT_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dsp_op_sequencer_if.slave     bus,
  output logic [WIDTH-1:0]      dsp_aa,
  output logic [WIDTH-1:0]      dsp_bb,
  output logic [2*WIDTH-1:0]    dsp_cc,
  output logic                  dsp_start,
  output logic [1:0]            dsp_mode,
  output logic                  dsp_mac,
  output logic                  dsp_shift_enable,
  output logic [SHIFT_BITS-1:0] dsp_shift_amount,
  output logic                  dsp_shift_dir,
  output logic                  dsp_rst,
  input  logic [2*WIDTH-1:0]    dsp_out,
  output logic                  busy
);

  localparam logic [1:0] OP_SHIFT = 2'd3;

  typedef enum logic [1:0] {IDLE, PRE, RUN} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               cnt, cnt_nxt;
  logic                     first_r, first_nxt;
  logic [1:0]               op_r;
  logic                     mac_r;
  logic [1:0]               fifo_cnt;
  logic                     wr_ptr, rd_ptr;
  logic [1:0][2*WIDTH-1:0]  mem;
  logic [1:0]               credit;
  logic                     last_run, accept, push, pop;

  function automatic logic [2:0] op_len(input logic [1:0] op);
    case (op)
      2'd0:    op_len = 3'd1;
      2'd1:    op_len = 3'd2;
      2'd2:    op_len = 3'd4;
      default: op_len = 3'd1;
    endcase
  endfunction

  assign last_run  = (state == RUN) && (cnt == 3'd1);
  assign pop       = bus.res_valid && bus.res_ready;
  assign push      = last_run;
  // At most one op is ever in flight, so credit never exceeds 3.
  assign credit    = fifo_cnt + {1'b0, state != IDLE};
  assign bus.req_ready = !dsp_rst && ((state == IDLE) || last_run) &&
                         ((credit < 2'd2) || ((credit == 2'd2) && pop));
  assign accept    = bus.req_valid && bus.req_ready;
  assign bus.res_valid = (fifo_cnt != 2'd0);
  assign bus.res_data  = mem[rd_ptr];
  assign busy      = (state != IDLE) || (fifo_cnt != 2'd0);

  always_comb begin
    dsp_start        = 1'b0;
    dsp_mode         = 2'd0;
    dsp_mac          = 1'b0;
    dsp_shift_enable = 1'b0;
    state_nxt        = state;
    cnt_nxt          = cnt;
    first_nxt        = 1'b0;
    case (state)
      PRE: begin
        dsp_mode  = op_r;
        dsp_mac   = 1'b1;
        state_nxt = RUN;
        cnt_nxt   = 3'd1;
        first_nxt = 1'b1;
      end
      RUN: begin
        dsp_start        = first_r;
        dsp_mode         = op_r;
        dsp_mac          = (op_r == OP_SHIFT) || mac_r;
        dsp_shift_enable = (op_r == OP_SHIFT);
        if (cnt == 3'd1) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 3'd1;
      end
      IDLE: ;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
    // A shift needs mac asserted in the cycle before it; if this cycle does
    // not provide that, spend one PRE cycle raising it.
    if (accept) begin
      if ((bus.req_op == OP_SHIFT) && !dsp_mac) begin
        state_nxt = PRE;
        cnt_nxt   = 3'd1;
        first_nxt = 1'b0;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = op_len(bus.req_op);
        first_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= 3'd0;
      first_r          <= 1'b0;
      op_r             <= 2'd0;
      mac_r            <= 1'b0;
      dsp_aa           <= '0;
      dsp_bb           <= '0;
      dsp_cc           <= '0;
      dsp_shift_amount <= '0;
      dsp_shift_dir    <= 1'b0;
      dsp_rst          <= 1'b1;
    end else begin
      dsp_rst <= 1'b0;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      first_r <= first_nxt;
      if (accept) begin
        op_r             <= bus.req_op;
        mac_r            <= bus.req_mac && (bus.req_op != OP_SHIFT);
        dsp_aa           <= bus.req_aa;
        dsp_bb           <= bus.req_bb;
        dsp_cc           <= bus.req_cc;
        dsp_shift_amount <= bus.req_shamt;
        dsp_shift_dir    <= bus.req_dir;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem      <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dsp_out;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Randomized scoreboard bench for dsp_op_sequencer with a behavioural DSP slice
// and an op-level reference model predicting control timelines and results.
module tb_dsp_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          rr_mode = 1;

  dsp_op_sequencer_if #(.WIDTH(33), .SHIFT_BITS(2)) bus ();

  logic [32:0] dsp_aa, dsp_bb;
  logic [65:0] dsp_cc, dsp_out;
  logic        dsp_start, dsp_mac, dsp_shift_enable, dsp_shift_dir, dsp_rst, busy;
  logic [1:0]  dsp_mode, dsp_shift_amount;

  dsp_op_sequencer #(.WIDTH(33), .SHIFT_BITS(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc),
    .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_mac(dsp_mac),
    .dsp_shift_enable(dsp_shift_enable), .dsp_shift_amount(dsp_shift_amount),
    .dsp_shift_dir(dsp_shift_dir), .dsp_rst(dsp_rst), .dsp_out(dsp_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rr_mode)
      0:       bus.res_ready = 1'b0;
      1:       bus.res_ready = 1'b1;
      default: bus.res_ready = (2'($urandom) != 2'd0);
    endcase
  end

  function automatic int op_len(input logic [1:0] m);
    case (m)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 1;
    endcase
  endfunction

  // Slice datapath semantics: MUL_S is 17x17, MUL_M 33x17, MUL_L 33x33.
  function automatic logic [65:0] prod(input logic [1:0] m, input logic [32:0] a, input logic [32:0] b);
    logic [65:0] x, y;
    x = {33'd0, a};
    y = {33'd0, b};
    if (m == 2'd0) begin x[65:17] = '0; y[65:17] = '0; end
    else if (m == 2'd1) y[65:17] = '0;
    return x * y;
  endfunction

  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
  endtask

  // ---------------- behavioural DSP slice ----------------
  logic [65:0] sl_acc, sl_base_r, sl_base;
  logic        sl_prev_mac, sl_last;
  logic [2:0]  sl_rem;

  always_comb begin
    sl_base = dsp_start ? ((dsp_mac && sl_prev_mac) ? sl_acc : dsp_cc) : sl_base_r;
    if (dsp_mode == 2'd3) dsp_out = dsp_shift_dir ? (sl_acc >> dsp_shift_amount) : (sl_acc << dsp_shift_amount);
    else                  dsp_out = prod(dsp_mode, dsp_aa, dsp_bb) + sl_base;
    sl_last = dsp_start ? (op_len(dsp_mode) == 1) : (sl_rem == 3'd1);
  end

  always @(posedge clk) begin
    if (dsp_rst) begin
      sl_acc <= '0; sl_base_r <= '0; sl_prev_mac <= 1'b0; sl_rem <= 3'd0;
    end else begin
      sl_prev_mac <= dsp_mac;
      if (dsp_start) begin
        sl_rem    <= 3'(op_len(dsp_mode) - 1);
        sl_base_r <= sl_base;
      end else if (sl_rem != 3'd0) sl_rem <= sl_rem - 3'd1;
      if (sl_last) sl_acc <= dsp_out;
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct {
    int          cyc;
    logic        st;
    logic [1:0]  mode;
    logic        mac;
    logic        sh;
    logic [32:0] aa, bb;
    logic [65:0] cc;
    logic [1:0]  shamt;
    logic        dir;
  } slot_t;

  typedef struct {
    logic [65:0] data;
    int          fin;
  } exp_t;

  slot_t       slot_q[$];
  exp_t        exp_q[$];
  slot_t       m_s;
  exp_t        m_e;
  logic [65:0] acc_m, m_res;
  int          prev_end, last_pop, m_len, m_st, m_vis;
  logic        prev_mace, head_seen, m_chain, m_pre, m_mace;

  always @(negedge clk) begin
    if (!rst) begin
      slot_q.delete(); exp_q.delete();
      acc_m = '0; prev_end = -100; prev_mace = 1'b0; last_pop = -100; head_seen = 1'b0;
    end else begin
      check("busy", 66'(busy), 66'(exp_q.size() != 0));
      if (slot_q.size() != 0 && slot_q[0].cyc == cyc) begin
        m_s = slot_q.pop_front();
        check("ctrl_start", 66'(dsp_start), 66'(m_s.st));
        check("ctrl_mode",  66'(dsp_mode),  66'(m_s.mode));
        check("ctrl_mac",   66'(dsp_mac),   66'(m_s.mac));
        check("ctrl_shen",  66'(dsp_shift_enable), 66'(m_s.sh));
        check("op_aa",      66'(dsp_aa),    66'(m_s.aa));
        check("op_bb",      66'(dsp_bb),    66'(m_s.bb));
        check("op_cc",      dsp_cc,         m_s.cc);
        check("op_shamt",   66'(dsp_shift_amount), 66'(m_s.shamt));
        check("op_dir",     66'(dsp_shift_dir), 66'(m_s.dir));
      end else begin
        check("idle_start", 66'(dsp_start), 66'(0));
        check("idle_mac",   66'(dsp_mac),   66'(0));
        check("idle_shen",  66'(dsp_shift_enable), 66'(0));
      end

      if (bus.res_valid) begin
        if (exp_q.size() == 0) check("spurious_result", 66'(bus.res_valid), 66'(0));
        else begin
          if (!head_seen) begin
            m_vis = (exp_q[0].fin + 1 > last_pop + 1) ? exp_q[0].fin + 1 : last_pop + 1;
            check("res_latency", 66'(cyc), 66'(m_vis));
            head_seen = 1'b1;
          end
          if (bus.res_ready) begin
            m_e = exp_q.pop_front();
            check("res_data", bus.res_data, m_e.data);
            last_pop = cyc;
            head_seen = 1'b0;
          end
        end
      end

      if (bus.req_valid && bus.req_ready) begin
        m_len   = op_len(bus.req_op);
        m_chain = (prev_end == cyc) && prev_mace;
        m_pre   = (bus.req_op == 2'd3) && !m_chain;
        m_st    = cyc + 1 + (m_pre ? 1 : 0);
        if (bus.req_op == 2'd3)
          m_res = bus.req_dir ? (acc_m >> bus.req_shamt) : (acc_m << bus.req_shamt);
        else
          m_res = prod(bus.req_op, bus.req_aa, bus.req_bb) + ((bus.req_mac && m_chain) ? acc_m : bus.req_cc);
        acc_m  = m_res;
        m_mace = (bus.req_op == 2'd3) || bus.req_mac;
        if (m_pre)
          slot_q.push_back('{cyc + 1, 1'b0, 2'd3, 1'b1, 1'b0, bus.req_aa, bus.req_bb,
                             bus.req_cc, bus.req_shamt, bus.req_dir});
        for (int i = 0; i < m_len; i++)
          slot_q.push_back('{m_st + i, (i == 0), bus.req_op, m_mace, (bus.req_op == 2'd3),
                             bus.req_aa, bus.req_bb, bus.req_cc, bus.req_shamt, bus.req_dir});
        exp_q.push_back('{m_res, m_st + m_len - 1});
        check("credit_depth", 66'(exp_q.size() <= 2), 66'(1));
        prev_end  = m_st + m_len - 1;
        prev_mace = m_mace;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input logic [1:0] op, input logic mac, input logic [32:0] aa,
                         input logic [32:0] bb, input logic [65:0] cc,
                         input logic [1:0] sh, input logic dir);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_mac = mac;
    bus.req_aa = aa; bus.req_bb = bb; bus.req_cc = cc;
    bus.req_shamt = sh; bus.req_dir = dir;
  endtask

  task automatic wait_accept();
    int  n;
    logic ok;
    n = 0; ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk); ok = bus.req_ready;
      @(posedge clk); #1; n++;
    end
    bus.req_valid = 1'b0;
    check("accept_in_time", 66'(ok), 66'(1));
  endtask

  task automatic issue(input logic [1:0] op, input logic mac, input logic [32:0] aa,
                       input logic [32:0] bb, input logic [65:0] cc,
                       input logic [1:0] sh, input logic dir);
    set_req(op, mac, aa, bb, cc, sh, dir);
    wait_accept();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dsp_rst",   66'(dsp_rst), 66'(1));
    check("rst_req_ready", 66'(bus.req_ready), 66'(0));
    check("rst_res_valid", 66'(bus.res_valid), 66'(0));
    check("rst_busy",      66'(busy), 66'(0));
    check("rst_start",     66'(dsp_start), 66'(0));
    check("rst_mode",      66'(dsp_mode), 66'(0));
    check("rst_res_data",  bus.res_data, 66'(0));
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("post_rst_pulse", 66'(dsp_rst), 66'(1));
    check("post_rst_ready", 66'(bus.req_ready), 66'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_pulse_end", 66'(dsp_rst), 66'(0));
    check("post_rst_ready_up",  66'(bus.req_ready), 66'(1));
    @(posedge clk); #1;
  endtask

  logic [1:0]  r_op, r_sh;
  logic        r_mac, r_dir;
  logic [32:0] r_aa, r_bb;
  logic [65:0] r_cc;
  int          n_wait;

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_mac = 1'b0;
    bus.req_aa = '0; bus.req_bb = '0; bus.req_cc = '0; bus.req_shamt = '0; bus.req_dir = 1'b0;
    do_reset();

    issue(2'd0, 1'b0, 33'd5, 33'd7, 66'd0, 2'd0, 1'b0);            // 35
    tick(3);
    issue(2'd2, 1'b0, 33'h12345, 33'h1000, 66'd0, 2'd0, 1'b0);     // 0x12345000
    tick(6);
    issue(2'd0, 1'b1, 33'd3, 33'd4, 66'd10, 2'd0, 1'b0);           // 22
    issue(2'd0, 1'b1, 33'd2, 33'd5, 66'd100, 2'd0, 1'b0);          // 32
    issue(2'd3, 1'b0, 33'd0, 33'd0, 66'd0, 2'd2, 1'b0);            // 128, no PRE
    tick(1);
    issue(2'd0, 1'b1, 33'd2, 33'd5, 66'd100, 2'd0, 1'b0);          // 110
    tick(2);
    issue(2'd3, 1'b0, 33'd0, 33'd0, 66'd0, 2'd1, 1'b1);            // 55, PRE inserted
    tick(4);

    // Backpressure: third op must wait for a pop.
    rr_mode = 0;
    tick(1);
    issue(2'd1, 1'b0, 33'h1_0000_0001, 33'h3, 66'd1, 2'd0, 1'b0);
    issue(2'd1, 1'b0, 33'd9, 33'd9, 66'd2, 2'd0, 1'b0);
    tick(4);
    set_req(2'd1, 1'b0, 33'd11, 33'd13, 66'd3, 2'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", 66'(bus.req_ready), 66'(0));
      @(posedge clk); #1;
    end
    rr_mode = 1;
    wait_accept();
    rr_mode = 0;
    tick(4);
    rr_mode = 1;
    tick(6);

    // Reset mid-MUL_L with a result sitting in the FIFO.
    rr_mode = 0;
    tick(1);
    issue(2'd0, 1'b0, 33'd8, 33'd8, 66'd0, 2'd0, 1'b0);
    issue(2'd2, 1'b0, 33'h1FFFFFFFF, 33'h1FFFFFFFF, 66'd0, 2'd0, 1'b0);
    tick(1);
    rr_mode = 1;
    do_reset();
    @(negedge clk);
    check("flush_res_valid", 66'(bus.res_valid), 66'(0));
    @(posedge clk); #1;
    issue(2'd0, 1'b0, 33'd6, 33'd7, 66'd0, 2'd0, 1'b0);            // 42
    tick(4);

    // Randomized traffic with random consumer stalls.
    rr_mode = 2;
    for (int k = 0; k < 200; k++) begin
      r_op  = 2'($urandom);
      r_mac = 1'($urandom);
      r_aa  = 33'({$urandom, $urandom});
      r_bb  = 33'({$urandom, $urandom});
      r_cc  = 66'({$urandom, $urandom, $urandom});
      r_sh  = 2'($urandom);
      r_dir = 1'($urandom);
      issue(r_op, r_mac, r_aa, r_bb, r_cc, r_sh, r_dir);
      tick(int'($urandom_range(2, 0)));
    end

    rr_mode = 1;
    n_wait = 0;
    while (exp_q.size() != 0 && n_wait < 200) begin tick(1); n_wait++; end
    check("drain_done", 66'(exp_q.size() == 0), 66'(1));
    tick(2);
    @(negedge clk);
    check("final_busy", 66'(busy), 66'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dsp_op_sequencer.md
Name: dsp_op_sequencer

Overview:
Front-end controller for the 33-bit fused multiply/accumulate DSP slice. It accepts operation requests over a valid/ready handshake and registers the operands. It then drives the slice's start/mode/mac/shift controls for the correct number of cycles per operation. Completed results are captured into a 2-entry result FIFO, so software-visible ops never overlap incorrectly and accumulate chains stay back-to-back.

Parameters:
WIDTH, 33, operand width of the DSP slice (result is 2*WIDTH)
SHIFT_BITS, 2, width of the accumulator shift amount

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&&ready
req_op  input  2  0=MUL_S (17x17, 1 cycle), 1=MUL_M (33x17, 2 cycles), 2=MUL_L (33x33, 4 cycles), 3=SHIFT accumulator
req_mac  input  1  accumulate onto previous result (ignored for SHIFT)
req_aa  input  WIDTH  operand A
req_bb  input  WIDTH  operand B
req_cc  input  2*WIDTH  addend (used when not accumulating)
req_shamt  input  SHIFT_BITS  shift amount for SHIFT
req_dir  input  1  shift direction, 0=left, 1=right
dsp_aa / dsp_bb  output  WIDTH  registered operands to slice
dsp_cc  output  2*WIDTH  registered addend to slice
dsp_start  output  1  first cycle of an operation
dsp_mode  output  2  slice mode (op code; 3 for SHIFT)
dsp_mac  output  1  slice mac control
dsp_shift_enable  output  1  slice shift enable
dsp_shift_amount  output  SHIFT_BITS  to slice
dsp_shift_dir  output  1  to slice
dsp_rst  output  1  synchronous clear for slice registers
dsp_out  input  2*WIDTH  slice combinational result
res_valid  output  1  result FIFO non-empty
res_ready  input  1  consumer pop
res_data  output  2*WIDTH  FIFO head
busy  output  1  op in progress or FIFO non-empty

Behaviour:
- Reset (rst=0):
  - All outputs 0 except dsp_rst=1.
  - FIFO empty; state IDLE.
  - dsp_rst stays 1 for exactly one clk cycle after rst deasserts.
  - req_ready=0 while dsp_rst=1.
- States: IDLE, PRE, RUN.
  - Operation length L: MUL_S=1, MUL_M=2, MUL_L=4, SHIFT=1.
  - Down-counter cnt tracks RUN cycles.
- Acceptance at cycle t:
  - Operands, op, mac, shamt and dir are latched into dsp_* registers.
  - The op starts in cycle t+1.
  - req_ready=1 only if the state is IDLE, or RUN with cnt==1 (last cycle, giving back-to-back issue).
  - Additionally, credit = fifo_count + ops_in_flight must be <2, or ==2 with a pop this cycle.
- RUN cycles:
  - dsp_start=1 on the first RUN cycle only.
  - dsp_mode=op and dsp_mac=latched mac, held for all L cycles.
  - dsp_shift_enable=0 for MUL ops.
  - Operands stay stable for all L cycles.
- SHIFT:
  - The slice needs mac=1 in the preceding cycle. If the previous cycle's dsp_mac was 0, insert one PRE cycle: dsp_start=0, dsp_mode=3, dsp_mac=1, shift_enable=0.
  - Then one RUN cycle: dsp_start=1, dsp_mode=3, dsp_mac=1, dsp_shift_enable=1.
  - Latency 1 when PRE is skipped, 2 when PRE is inserted.
- Accumulation:
  - Accumulation happens only when the previous cycle drove dsp_mac=1, i.e. a back-to-back mac op.
  - A mac op issued after an IDLE cycle loads cc instead.
  - In IDLE, dsp_mac=0 and dsp_start=0.
  - A non-mac MUL returns aa*bb+cc.
- Result capture:
  - On the last RUN cycle, dsp_out is written into the FIFO at the clock edge.
  - res_valid rises at t+1+L (+1 if PRE was inserted).
  - A simultaneous push and pop on a full FIFO is legal; count is unchanged.
  - Credit rules make overflow impossible. Overflow is an assertion failure in the bench.
- FIFO: depth 2, first-word fall-through, res_data stable while res_valid&&!res_ready.
- Invalid states: req_op outside its encoding cannot occur (2-bit op). An illegal state returns to IDLE.
- Reset mid-operation: the op is aborted, the FIFO is flushed and dsp_rst is pulsed as above.

Test Plan:
- MUL_S, aa=5, bb=7, cc=0, mac=0 -> dsp_start high 1 cycle, mode 0; res_data=35 at t+2.
- MUL_L, aa=0x12345, bb=0x1000, cc=0 -> start high only on the first of 4 RUN cycles, mode 2 held; res_data=0x12345000 at t+5.
- MAC chain, after idle:
  - Op A: MUL_S aa=3, bb=4, cc=10, mac=1 -> 22.
  - Op B, issued back-to-back: aa=2, bb=5, mac=1 -> 32.
  - Repeat B after one idle cycle -> 10+cc of B.
- SHIFT left by 2 directly after the chain above -> no PRE cycle, res_data=128. SHIFT after idle -> PRE cycle inserted, latency 2.
- Backpressure: hold res_ready=0, issue 3 MUL_M ops -> 2 results queued, req_ready=0 for the third. Pulse res_ready -> third accepted, order preserved.
- Assert rst mid-MUL_L -> FIFO empty, dsp_rst high for 1 cycle after release, then a fresh MUL_S 6*7 -> 42.
